// File: rtl/sort4_group_loader_pkg.sv
// Shared lane geometry for the 4-number sorter and its group loader.
// Lane k of a packed group occupies bits [DW*(k+1)-1 : DW*k].
package sort4_group_loader_pkg;

  localparam int NLANES = 4;
  localparam int CNT_W  = 2;
  localparam int OCNT_W = 3;
  localparam int MAX_DW = 64;

  function automatic logic [MAX_DW-1:0] pad_word(
    input int dw,
    input bit pad_high
  );
    logic [MAX_DW-1:0] p;
    p = '0;
    for (int i = 0; i < MAX_DW; i++) begin
      p[i] = pad_high && (i < dw);
    end
    return p;
  endfunction

endpackage

// File: rtl/sort4_group_loader.sv
// Packs a serial word stream into padded 4-lane groups for the sorter.
// Flush closes a partial group; a same-cycle word joins it first.
module sort4_group_loader
  import sort4_group_loader_pkg::*;
#(
  parameter int DW       = 8,
  parameter bit PAD_HIGH = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DW-1:0]        in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic                 flush_ready,
  output logic [NLANES*DW-1:0] out_data,
  output logic [OCNT_W-1:0]    out_count,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam logic [MAX_DW-1:0] PADW = pad_word(DW, PAD_HIGH);
  localparam logic [DW-1:0]     PAD  = PADW[DW-1:0];
  localparam logic [CNT_W-1:0]  LAST = CNT_W'(NLANES - 1);

  logic [CNT_W-1:0]     cnt;
  logic [NLANES*DW-1:0] lanes;
  logic [NLANES*DW-1:0] lanes_nx;
  logic [NLANES*DW-1:0] grp;
  logic [OCNT_W-1:0]    nreal;
  logic                 out_free;
  logic                 acc;
  logic                 close;

  always_comb begin
    out_free    = !out_valid || out_ready;
    in_ready    = (cnt != LAST) || out_free;
    flush_ready = out_free;
    acc         = in_valid && in_ready;
    nreal       = OCNT_W'(cnt) + OCNT_W'(acc);
    close       = (acc && cnt == LAST)
               || (flush && out_free && nreal != '0);
    lanes_nx    = lanes;
    grp         = '0;
    for (int k = 0; k < NLANES; k++) begin
      if (acc && cnt == CNT_W'(k)) begin
        lanes_nx[k*DW +: DW] = in_data;
      end
    end
    // Lanes past the real word count carry PAD
    for (int k = 0; k < NLANES; k++) begin
      grp[k*DW +: DW] = (OCNT_W'(k) < nreal)
                      ? lanes_nx[k*DW +: DW] : PAD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      lanes     <= '0;
      out_data  <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
    end else if (close) begin
      cnt       <= '0;
      lanes     <= '0;
      out_data  <= grp;
      out_count <= nreal;
      out_valid <= 1'b1;
    end else begin
      if (acc) begin
        lanes <= lanes_nx;
        cnt   <= cnt + 1'b1;
      end
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sort4_group_loader.sv
// Bench for the group loader: queue-level model plus directed cases.
// Two instances differ only in pad polarity.
module tb_sort4_group_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic        in_ready, flush_ready, out_valid;
  logic [31:0] out_data;
  logic [2:0]  out_count;
  logic        in_ready0, flush_ready0, out_valid0;
  logic [31:0] out_data0;
  logic [2:0]  out_count0;

  int ntests = 0;
  int nfail  = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  sort4_group_loader #(.DW(8), .PAD_HIGH(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .flush_ready(flush_ready),
    .out_data(out_data), .out_count(out_count),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  sort4_group_loader #(.DW(8), .PAD_HIGH(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .flush(flush), .flush_ready(flush_ready0),
    .out_data(out_data0), .out_count(out_count0),
    .out_valid(out_valid0), .out_ready(out_ready)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: pending words queue and the held output group
  logic [7:0]  cur[$];
  bit          m_ov = 1'b0;
  logic [31:0] m_d1 = '0;
  logic [31:0] m_d0 = '0;
  int          m_oc = 0;

  always @(posedge clk) begin
    bit free;
    bit rdy;
    if (rst) begin
      cur.delete();
      m_ov = 1'b0;
      started = 1'b1;
    end else begin
      free = !m_ov || out_ready;
      rdy  = (cur.size() != 3) || free;
      if (in_valid && rdy) cur.push_back(in_data);
      if (cur.size() == 4 || (flush && free && cur.size() > 0)) begin
        m_oc = cur.size();
        m_d1 = 32'hFFFF_FFFF;
        m_d0 = 32'h0;
        for (int i = 0; i < m_oc; i++) begin
          m_d1[i*8 +: 8] = cur[i];
          m_d0[i*8 +: 8] = cur[i];
        end
        cur.delete();
        m_ov = 1'b1;
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    bit free;
    if (started) begin
      free = !m_ov || out_ready;
      chk("in_ready", 64'(in_ready), 64'((cur.size() != 3) || free));
      chk("in_ready0", 64'(in_ready0), 64'((cur.size() != 3) || free));
      chk("flush_ready", 64'(flush_ready), 64'(free));
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      chk("out_valid0", 64'(out_valid0), 64'(m_ov));
      if (m_ov) begin
        chk("out_data", 64'(out_data), 64'(m_d1));
        chk("out_data0", 64'(out_data0), 64'(m_d0));
        chk("out_count", 64'(out_count), 64'(m_oc));
        chk("out_count0", 64'(out_count0), 64'(m_oc));
      end
    end
  end

  // Group handoff timing, for the stride check
  int cyc = 0;
  int gcyc[$];
  always @(posedge clk) begin
    cyc++;
    if (!rst && out_valid && out_ready) gcyc.push_back(cyc);
  end

  task automatic step(input logic v, input logic [7:0] d,
                      input logic f, input logic r);
    in_valid  = v;
    in_data   = d;
    flush     = f;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    logic [7:0] w;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data", 64'(out_data), 64'(0));
    chk("rst_count", 64'(out_count), 64'(0));
    rst = 1'b0;

    step(1'b1, 8'h10, 1'b0, 1'b1);
    step(1'b1, 8'h03, 1'b0, 1'b1);
    step(1'b1, 8'hFF, 1'b0, 1'b1);
    step(1'b1, 8'h42, 1'b0, 1'b1);
    chk("full_valid", 64'(out_valid), 64'(1));
    chk("full_data", 64'(out_data), 64'(32'h42FF_0310));
    chk("full_count", 64'(out_count), 64'(4));
    idle();

    step(1'b1, 8'h05, 1'b0, 1'b1);
    step(1'b1, 8'h07, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("fl2_pad1", 64'(out_data), 64'(32'hFFFF_0705));
    chk("fl2_pad0", 64'(out_data0), 64'(32'h0000_0705));
    chk("fl2_count", 64'(out_count), 64'(2));

    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("fl_empty", 64'(out_valid), 64'(0));

    step(1'b1, 8'h21, 1'b0, 1'b1);
    step(1'b1, 8'h22, 1'b0, 1'b1);
    step(1'b1, 8'h23, 1'b1, 1'b1);
    chk("fl3_count", 64'(out_count), 64'(3));
    chk("fl3_data", 64'(out_data), 64'(32'hFF23_2221));
    idle();

    for (int i = 0; i < 4; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hB3;
    #1;
    chk("bp_inrdy", 64'(in_ready), 64'(0));
    chk("bp_hold", 64'(out_data), 64'(32'hA3A2_A1A0));
    @(posedge clk);
    #1;
    chk("bp_hold2", 64'(out_data), 64'(32'hA3A2_A1A0));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_next", 64'(out_data), 64'(32'hB3B2_B1B0));
    chk("bp_nextv", 64'(out_valid), 64'(1));
    idle();

    step(1'b1, 8'hE1, 1'b0, 1'b1);
    step(1'b1, 8'hE2, 1'b0, 1'b1);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    chk("rstmid_v", 64'(out_valid), 64'(0));
    for (int i = 0; i < 4; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b1);
    chk("rstmid_data", 64'(out_data), 64'(32'hC3C2_C1C0));
    for (int i = 0; i < 4; i++) step(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0);
    chk("held_v", 64'(out_valid), 64'(1));
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    chk("rsthold_v", 64'(out_valid), 64'(0));
    chk("rsthold_cnt", 64'(out_count), 64'(0));
    idle();

    gcyc.delete();
    for (int i = 0; i < 32; i++) begin
      w = 8'($urandom);
      step(1'b1, w, 1'b0, 1'b1);
    end
    repeat (3) idle();
    chk("burst_groups", 64'(gcyc.size()), 64'(8));
    for (int i = 1; i < gcyc.size(); i++) begin
      chk("burst_stride", 64'(gcyc[i] - gcyc[i-1]), 64'(4));
    end

    for (int i = 0; i < 400; i++) begin
      w = 8'($urandom);
      step(($urandom % 4) != 0, w, ($urandom % 6) == 0,
           ($urandom % 3) != 0);
    end
    repeat (3) idle();

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
